// File: rtl/tick_pwm_pkg.sv
// rtl/tick_pwm_pkg.sv - shared state encoding and default sizing for tick_pwm
package tick_pwm_pkg;

  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned DEAD_CYC_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - dead-time insertion between complementary PWM outputs
module pwm_deadtime #(
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic run_i,
  input  logic raw_i,
  output logic pwm_o,
  output logic pwm_n_o
);

  localparam int unsigned   DW      = $clog2(DEAD_CYC + 1) + 1;
  localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_CYC);

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          tgt_q, tgt_d;
  logic          p_q, p_d;
  logic          n_q, n_d;

  // Any raw change forces both sides off and restarts the dead interval;
  // only a level that survives the whole interval reaches its output.
  always_comb begin
    dcnt_d = dcnt_q;
    tgt_d  = tgt_q;
    p_d    = p_q;
    n_d    = n_q;
    if (!run_i) begin
      dcnt_d = DEAD_LD;
      tgt_d  = 1'b0;
      p_d    = 1'b0;
      n_d    = 1'b0;
    end else if (raw_i != tgt_q) begin
      dcnt_d = DEAD_LD;
      tgt_d  = raw_i;
      p_d    = 1'b0;
      n_d    = 1'b0;
    end else if (dcnt_q > DW'(1)) begin
      dcnt_d = dcnt_q - DW'(1);
    end else begin
      dcnt_d = '0;
      p_d    = tgt_q;
      n_d    = !tgt_q;
    end
  end

  // Dead-time state and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dcnt_q <= DEAD_LD;
      tgt_q  <= 1'b0;
      p_q    <= 1'b0;
      n_q    <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      tgt_q  <= tgt_d;
      p_q    <= p_d;
      n_q    <= n_d;
    end
  end

  assign pwm_o   = p_q;
  assign pwm_n_o = n_q;

endmodule

// File: rtl/tick_pwm.sv
// rtl/tick_pwm.sv - tick-driven PWM with boundary-aligned config update
// Optional build macro TICK_PWM_DEADTIME_EN adds pwm_n_o with dead-time insertion.
module tick_pwm
  import tick_pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [CNT_W-1:0] cfg_duty_i,
  output logic             pwm_o,
`ifdef TICK_PWM_DEADTIME_EN
  output logic             pwm_n_o,
`endif
  output logic             wrap_o
);

  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("tick_pwm: CNT_W must be at least 2");
  end
  if (DEAD_CYC < 1) begin : g_bad_dead_cyc
    $error("tick_pwm: DEAD_CYC must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_p_q, act_p_d, act_d_q, act_d_d;
  logic [CNT_W-1:0] pend_p_q, pend_p_d, pend_d_q, pend_d_d;
  logic             pend_v_q, pend_v_d;
  logic             live_q;
  logic             pwm_q, pwm_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] last_cnt;
  logic             run_entry, run_tick, at_end, apply, xfer;

  // Ready stays low until the first clock with reset released.
  assign cfg_ready_o = live_q && !pend_v_q;

  // A period of zero ticks behaves as a one-tick period.
  assign last_cnt = (act_p_q == '0) ? '0 : act_p_q - CNT_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state follows the run enable level.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i)  state_d = RUN;
      RUN:     if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter, config apply and output next-state.
  always_comb begin
    run_entry = (state_q == IDLE) && en_i;
    run_tick  = (state_q == RUN) && en_i && tick_i;
    at_end    = (cnt_q == last_cnt);
    apply     = pend_v_q && (run_entry || (run_tick && at_end));
    xfer      = cfg_valid_i && cfg_ready_o;

    act_p_d   = apply ? pend_p_q : act_p_q;
    act_d_d   = apply ? pend_d_q : act_d_q;
    pend_p_d  = xfer ? cfg_period_i : pend_p_q;
    pend_d_d  = xfer ? cfg_duty_i : pend_d_q;
    pend_v_d  = apply ? 1'b0 : (xfer ? 1'b1 : pend_v_q);

    cnt_d  = cnt_q;
    pwm_d  = pwm_q;
    wrap_d = 1'b0;
    if (state_d == IDLE) begin
      cnt_d = '0;
      pwm_d = 1'b0;
    end else if (run_entry) begin
      cnt_d = '0;
      pwm_d = (act_d_d != '0);
    end else if (run_tick) begin
      cnt_d  = at_end ? '0 : cnt_q + CNT_W'(1);
      pwm_d  = (cnt_d < act_d_d);
      wrap_d = at_end;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      live_q   <= 1'b0;
      cnt_q    <= '0;
      act_p_q  <= CNT_W'(1);
      act_d_q  <= '0;
      pend_p_q <= '0;
      pend_d_q <= '0;
      pend_v_q <= 1'b0;
      pwm_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      live_q   <= 1'b1;
      cnt_q    <= cnt_d;
      act_p_q  <= act_p_d;
      act_d_q  <= act_d_d;
      pend_p_q <= pend_p_d;
      pend_d_q <= pend_d_d;
      pend_v_q <= pend_v_d;
      pwm_q    <= pwm_d;
      wrap_q   <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;

`ifdef TICK_PWM_DEADTIME_EN
  pwm_deadtime #(
    .DEAD_CYC (DEAD_CYC)
  ) u_deadtime (
    .clk     (clk),
    .rstn    (rstn),
    .run_i   (state_d == RUN),
    .raw_i   (pwm_q),
    .pwm_o   (pwm_o),
    .pwm_n_o (pwm_n_o)
  );
`else
  assign pwm_o = pwm_q;
`endif

endmodule

// File: tb/tb_tick_pwm.sv
// tb/tb_tick_pwm.sv - self-checking bench for tick_pwm
module tb_tick_pwm;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick_i = 1'b0;
  logic       en_i = 1'b0;
  logic       cfg_valid_i = 1'b0;
  logic       cfg_ready_o;
  logic [7:0] cfg_period_i = '0;
  logic [7:0] cfg_duty_i = '0;
  logic       pwm_o;
  logic       wrap_o;
`ifdef TICK_PWM_DEADTIME_EN
  logic       pwm_n_o;
`endif

  tick_pwm #(.CNT_W(8), .DEAD_CYC(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .tick_i       (tick_i),
    .en_i         (en_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_period_i (cfg_period_i),
    .cfg_duty_i   (cfg_duty_i),
    .pwm_o        (pwm_o),
`ifdef TICK_PWM_DEADTIME_EN
    .pwm_n_o      (pwm_n_o),
`endif
    .wrap_o       (wrap_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pwm;
    bit wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // stimulus state
  bit   en = 0;
  bit   offer = 0;
  int   cfg_p = 0;
  int   cfg_d = 0;

  // reference model of the tick-domain behaviour
  bit   m_live, m_run, m_pv, m_pwm, m_wrap;
  int   m_cnt, m_P, m_D, m_pP, m_pD;

  // observation
  int   cyc = 0;
  int   acc_cyc = -1;
  int   last_wrap_cyc = -1;
  int   pwm_hi = 0;
  int   wraps = 0;
`ifdef TICK_PWM_DEADTIME_EN
  bit   prev_p = 0, prev_n = 0;
  int   n_fall_cyc = -1, p_fall_cyc = -1, gaps_seen = 0;
`endif

  task automatic step(input bit tk);
    bit   rdy_exp, xfer;
    int   per;
    exp_t e;
    tick_i       = tk;
    en_i         = en;
    cfg_valid_i  = offer;
    cfg_period_i = 8'(cfg_p);
    cfg_duty_i   = 8'(cfg_d);
    rdy_exp = m_live && !m_pv;
    n_tests++;
    if (cfg_ready_o !== rdy_exp) begin
      n_fail++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, cfg_ready_o, rdy_exp);
    end
    xfer = offer && rdy_exp;
    if (!m_run) begin
      if (en) begin
        if (m_pv) begin m_P = m_pP; m_D = m_pD; m_pv = 0; end
        m_run = 1; m_cnt = 0; m_pwm = (m_D != 0);
      end else begin
        m_cnt = 0; m_pwm = 0;
      end
      m_wrap = 0;
    end else if (!en) begin
      m_run = 0; m_cnt = 0; m_pwm = 0; m_wrap = 0;
    end else if (tk) begin
      per = (m_P == 0) ? 1 : m_P;
      m_cnt++;
      m_wrap = (m_cnt == per);
      if (m_wrap) begin
        m_cnt = 0;
        if (m_pv) begin m_P = m_pP; m_D = m_pD; m_pv = 0; end
      end
      m_pwm = (m_cnt < m_D);
    end else begin
      m_wrap = 0;
    end
    if (xfer) begin m_pP = cfg_p; m_pD = cfg_d; m_pv = 1; end
    m_live = 1;
    e.pwm = m_pwm; e.wrap = m_wrap;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cyc++;
    if (xfer) begin offer = 0; acc_cyc = cyc; end
    e = exp_q.pop_front();
`ifndef TICK_PWM_DEADTIME_EN
    n_tests++;
    if (pwm_o !== e.pwm) begin
      n_fail++;
      $display("FAIL pwm cyc=%0d got=%b exp=%b", cyc, pwm_o, e.pwm);
    end
`endif
    n_tests++;
    if (wrap_o !== e.wrap) begin
      n_fail++;
      $display("FAIL wrap cyc=%0d got=%b exp=%b", cyc, wrap_o, e.wrap);
    end
    if (wrap_o === 1'b1) begin wraps++; last_wrap_cyc = cyc; end
    if (pwm_o === 1'b1) pwm_hi++;
`ifdef TICK_PWM_DEADTIME_EN
    n_tests++;
    if (pwm_o === 1'b1 && pwm_n_o === 1'b1) begin
      n_fail++;
      $display("FAIL overlap cyc=%0d got=both_high exp=not_both", cyc);
    end
    if (prev_n && !pwm_n_o) n_fall_cyc = cyc;
    if (prev_p && !pwm_o) p_fall_cyc = cyc;
    if (!prev_p && pwm_o && n_fall_cyc >= 0) begin
      n_tests++; gaps_seen++;
      if (cyc - n_fall_cyc != 2) begin
        n_fail++;
        $display("FAIL rise_gap cyc=%0d got=%0d exp=2", cyc, cyc - n_fall_cyc);
      end
    end
    if (!prev_n && pwm_n_o && p_fall_cyc >= 0) begin
      n_tests++; gaps_seen++;
      if (cyc - p_fall_cyc != 2) begin
        n_fail++;
        $display("FAIL fall_gap cyc=%0d got=%0d exp=2", cyc, cyc - p_fall_cyc);
      end
    end
    prev_p = pwm_o; prev_n = pwm_n_o;
`endif
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      for (int j = 0; j < gap - 1; j++) step(1'b0);
    end
  endtask

  task automatic do_reset();
    rstn = 0; en = 0; offer = 0;
    en_i = 0; tick_i = 0; cfg_valid_i = 0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_tests += 3;
      if (cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", cfg_ready_o); end
      if (pwm_o !== 1'b0) begin n_fail++; $display("FAIL rst_pwm got=%b exp=0", pwm_o); end
      if (wrap_o !== 1'b0) begin n_fail++; $display("FAIL rst_wrap got=%b exp=0", wrap_o); end
    end
    m_live = 0; m_run = 0; m_pv = 0; m_pwm = 0; m_wrap = 0;
    m_cnt = 0; m_P = 1; m_D = 0; m_pP = 0; m_pD = 0;
    rstn = 1;
  endtask

  task automatic set_cfg(input int p, input int d);
    cfg_p = p; cfg_d = d; offer = 1;
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0);
    n_tests++;
    if (cfg_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release got=%b exp=1", cfg_ready_o);
    end
  endtask

  task automatic test_basic();
    set_cfg(4, 1);
    step(1'b0);
    en = 1;
    step(1'b0);
    pwm_hi = 0; wraps = 0;
    run_ticks(16, 4);
    n_tests += 2;
    if (wraps != 4) begin n_fail++; $display("FAIL basic_wraps got=%0d exp=4", wraps); end
    if (pwm_hi != 16) begin n_fail++; $display("FAIL basic_high got=%0d exp=16", pwm_hi); end
  endtask

  task automatic test_duty_edges();
    set_cfg(4, 0);
    run_ticks(12, 2);
    pwm_hi = 0;
    run_ticks(8, 2);
    n_tests++;
    if (pwm_hi != 0) begin n_fail++; $display("FAIL duty0_high got=%0d exp=0", pwm_hi); end
    set_cfg(4, 5);
    run_ticks(12, 2);
    pwm_hi = 0;
    run_ticks(8, 2);
    n_tests++;
    if (pwm_hi != 16) begin n_fail++; $display("FAIL dutyfull_high got=%0d exp=16", pwm_hi); end
    set_cfg(0, 1);
    run_ticks(8, 2);
    pwm_hi = 0; wraps = 0;
    run_ticks(6, 1);
    n_tests += 2;
    if (wraps != 6) begin n_fail++; $display("FAIL p0_wraps got=%0d exp=6", wraps); end
    if (pwm_hi != 6) begin n_fail++; $display("FAIL p0_high got=%0d exp=6", pwm_hi); end
  endtask

  task automatic test_pending();
    int wrap_at;
    set_cfg(4, 2);
    run_ticks(8, 3);
    run_ticks(2, 3);
    set_cfg(8, 4);
    step(1'b0);
    n_tests += 2;
    if (offer !== 1'b0) begin n_fail++; $display("FAIL first_accept got=held exp=accepted"); end
    if (cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL ready_drop got=%b exp=0", cfg_ready_o); end
    set_cfg(3, 1);
    last_wrap_cyc = -1;
    run_ticks(4, 3);
    wrap_at = last_wrap_cyc;
    n_tests += 2;
    if (offer !== 1'b0) begin n_fail++; $display("FAIL second_accept got=held exp=accepted"); end
    if (acc_cyc != wrap_at + 1) begin
      n_fail++;
      $display("FAIL accept_after_apply got=%0d exp=%0d", acc_cyc, wrap_at + 1);
    end
    run_ticks(12, 1);
  endtask

  task automatic test_en_drop_reset();
    run_ticks(10, 1);
    run_ticks(1, 1);
    en = 0;
    step(1'b0);
    n_tests++;
    if (pwm_o !== 1'b0) begin n_fail++; $display("FAIL en_drop_pwm got=%b exp=0", pwm_o); end
    set_cfg(2, 1);
    step(1'b1);
    step(1'b0);
    en = 1;
    step(1'b0);
    n_tests++;
    if (pwm_o !== 1'b1) begin n_fail++; $display("FAIL reentry_pwm got=%b exp=1", pwm_o); end
    run_ticks(5, 1);
    do_reset();
    en = 1;
    step(1'b0);
    pwm_hi = 0; wraps = 0;
    run_ticks(4, 1);
    n_tests += 2;
    if (wraps != 4) begin n_fail++; $display("FAIL post_rst_wraps got=%0d exp=4", wraps); end
    if (pwm_hi != 0) begin n_fail++; $display("FAIL post_rst_high got=%0d exp=0", pwm_hi); end
  endtask

`ifdef TICK_PWM_DEADTIME_EN
  task automatic test_deadtime();
    do_reset();
    step(1'b0);
    set_cfg(8, 4);
    step(1'b0);
    en = 1;
    n_fall_cyc = -1; p_fall_cyc = -1; gaps_seen = 0;
    run_ticks(40, 1);
    n_tests++;
    if (gaps_seen < 6) begin n_fail++; $display("FAIL dead_gaps got=%0d exp=>=6", gaps_seen); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TICK_PWM_DEADTIME_EN
    test_deadtime();
`else
    test_basic();
    test_duty_edges();
    test_pending();
    test_en_drop_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tick_pwm.md
# tick_pwm

Tick-driven PWM generator sitting directly downstream of the periodic pulse generator: it consumes the one-cycle `tick_i` strobe as its count enable and produces a PWM waveform whose period and duty are expressed in ticks. New period/duty settings arrive over a valid/ready handshake and take effect only at a period boundary, so the output never shows a truncated or glitched period. A one-cycle `wrap_o` strobe marks each period end for downstream sequencing.

## Interface
- `CNT_W`, default 8: width of period, duty and tick counter.
- `DEAD_CYC`, default 2: dead time in clk cycles; used only with `TICK_PWM_DEADTIME_EN`.

- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `tick_i`  in  1  one-cycle count strobe from the pulse generator.
- `en_i`  in  1  run enable, level.
- `cfg_valid_i`  in  1  config offer.
- `cfg_ready_o`  out  1  config slot free.
- `cfg_period_i`  in  CNT_W  period P in ticks.
- `cfg_duty_i`  in  CNT_W  high time D in ticks.
- `pwm_o`  out  1  PWM output, registered.
- `pwm_n_o`  out  1  complementary output; exists only with the macro.
- `wrap_o`  out  1  one-cycle period-end strobe, registered.

## Operation
- State machine: IDLE, RUN.
  - IDLE→RUN when `en_i`=1.
  - RUN→IDLE when `en_i`=0.
  - Both transitions complete in one clk.
- Active registers: `act_P` and `act_D`. Pending slot: `pend_P`, `pend_D`, `pend_v`.
- Handshake:
  - `cfg_ready_o` = !`pend_v` while out of reset.
  - A transfer occurs when `cfg_valid_i` && `cfg_ready_o`; it loads the pending slot and sets `pend_v`.
  - A valid held while ready is low is held off, not dropped.
- Apply rule: the pending slot moves to the active registers and `pend_v` clears when either:
  - a tick wraps the counter in RUN, or
  - on the IDLE→RUN transition.
  - A transfer in the same cycle as an apply lands in the now-empty slot only if ready was already high; no bypass into active.
- Counter `cnt`:
  - Advances only on `tick_i` in RUN: 0..`act_P`-1, then back to 0.
  - P=0 is treated as P=1.
  - Wrap arithmetic is unsigned CNT_W; no overflow at P=2^CNT_W-1.
- Output value: `pwm_o` = (cnt_next < act_D_next), evaluated on RUN ticks and on RUN entry.
  - D=0 → constantly low.
  - D≥P → constantly high.
- `wrap_o`: pulses for one cycle after any tick where cnt = P-1, including P=1, where it pulses on every tick.
- IDLE:
  - `cnt`=0, `pwm_o`=0, `wrap_o`=0.
  - `tick_i` is ignored.
  - Handshake still operates.

## Timing
- Reset values:
  - `pwm_o`=0, `wrap_o`=0, `cfg_ready_o`=0 during reset and 1 the cycle after release.
  - `pend_v`=0, `act_P`=1, `act_D`=0, state IDLE.
- Latency:
  - `pwm_o` and `wrap_o` change in the cycle after the qualifying tick edge.
  - RUN entry: `pwm_o` = (D≠0) one cycle after `en_i` is sampled high.
- Reset mid-operation: immediate return to reset values; the pending config is lost.
- `en_i` drop mid-period: `pwm_o` goes low next cycle. A pending config is applied at the next RUN entry.
- Back-to-back ticks on consecutive clks are legal; every tick counts.

## Configuration
- Macro: `TICK_PWM_DEADTIME_EN`.
- Without the macro:
  - No `pwm_n_o` port.
  - `pwm_o` is the raw comparison output as described above.
- With the macro:
  - `pwm_n_o` exists.
  - Raw rising edge: `pwm_n_o` falls next cycle; `pwm_o` rises DEAD_CYC cycles after that.
  - Raw falling edge: the mirror of the above.
  - Both outputs are never high together.
  - A raw pulse shorter than DEAD_CYC produces no `pwm_o` pulse.
  - In IDLE and reset, both outputs are 0.

## Structure
- Package `tick_pwm_pkg`: state enum (IDLE, RUN) and the default `CNT_W`/`DEAD_CYC` constants.
- One sub-module `pwm_deadtime`: dead-time insertion with its own counter and `DEAD_CYC` parameter, instantiated only under the macro.

## Test plan
- P=4, D=1, tick every 4 clks → `pwm_o` high 1 tick of every 4; `wrap_o` pulses once per 4 ticks, one clk after the tick with cnt=3.
- D=0 → `pwm_o` stays 0. D=5 with P=4 → `pwm_o` stays 1. P=0 → behaves as P=1, `wrap_o` pulses on every tick.
- Offer P=8, D=4 mid-period while running P=4, D=2 → `cfg_ready_o` drops; old period completes; new values apply at the wrap; `cfg_ready_o` returns high.
- Second config offered while `pend_v`=1 → held off with `cfg_valid_i` asserted; accepted the cycle after the apply.
- Drop `en_i` and assert `rstn`=0 mid-period → `pwm_o`=0 next cycle; after re-enable the count restarts at 0 with `act_P`=1, `act_D`=0 following reset.
- With macro, DEAD_CYC=2, P=8, D=4 → `pwm_o`/`pwm_n_o` never high together; 2-clk gaps at both edges.
